conv_enc_k7: RTL and testbench



---
 rtl/viterbi_k7_pkg.sv | 20 ++
 rtl/conv_k7_branch.sv | 12 +
 rtl/conv_enc_k7.sv | 148 ++++++++++++++
 tb/tb_conv_enc_k7.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_k7_pkg.sv
// Shared constants and types for the K=7 rate-1/2 code (171/133 octal).
// The encoder and the Viterbi decoder blocks both use this package.
package viterbi_k7_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned STATE_W    = K - 1;
  localparam int unsigned TAIL_LEN   = K - 1;
  localparam int unsigned TAIL_CNT_W = 3;
  localparam int unsigned SYM_W      = 2;

  localparam logic [K-1:0] G0 = 7'o171;
  localparam logic [K-1:0] G1 = 7'o133;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/conv_k7_branch.sv
// Combinational code-symbol generator: window {b, sr} -> {c1, c0}.
// Window MSB is the current input bit; also usable as the decoder's expected-symbol source.
module conv_k7_branch
  import viterbi_k7_pkg::*;
(
  input  logic [K-1:0]     win,
  output logic [SYM_W-1:0] sym_c
);

  assign sym_c = {^(win & G1), ^(win & G0)};

endmodule

// File: rtl/conv_enc_k7.sv
// Streaming K=7 rate-1/2 convolutional encoder with K-1 zero tail bits per frame.
// Optional rate-2/3 puncture mask generation under macro CONV_PUNCT_EN.
module conv_enc_k7
  import viterbi_k7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic [SYM_W-1:0] out_mask,
  output logic             out_last,
  output logic             busy
);

  enc_state_e              state, state_nx;
  logic [STATE_W-1:0]      sr, sr_nx;
  logic [TAIL_CNT_W-1:0]   tail_cnt, tail_nx;
  logic                    out_valid_nx, out_last_nx, busy_nx;
  logic [SYM_W-1:0]        out_data_nx, out_mask_nx;
  logic                    adv, accept, step, step_bit;
  logic [K-1:0]            win;
  logic [SYM_W-1:0]        sym_c;

  // The output register can take a new symbol when empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && (state != TAIL);
  assign accept   = in_valid && in_ready;
  assign step_bit = (state == TAIL) ? 1'b0 : in_data;
  assign win      = {step_bit, sr};

  conv_k7_branch u_branch (
    .win   (win),
    .sym_c (sym_c)
  );

`ifdef CONV_PUNCT_EN
  logic sym_odd, sym_odd_nx;
  logic frame_start;

  assign frame_start = (state == IDLE);

  // Parity of the next symbol index within the frame; restarts on each frame's first bit.
  always_comb begin
    sym_odd_nx  = sym_odd;
    out_mask_nx = out_mask;
    if (step) begin
      if (frame_start || !sym_odd) begin
        out_mask_nx = 2'b11;
      end else begin
        out_mask_nx = 2'b01;
      end
      sym_odd_nx = frame_start ? 1'b1 : !sym_odd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_odd <= 1'b0;
    end else begin
      sym_odd <= sym_odd_nx;
    end
  end
`else
  assign out_mask_nx = 2'b11;
`endif

  // Next-state, shift register and output register update.
  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    tail_nx      = tail_cnt;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_last_nx  = out_last;
    step         = 1'b0;

    if (adv) begin
      out_valid_nx = 1'b0;
      out_last_nx  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          step     = 1'b1;
          tail_nx  = '0;
          state_nx = in_last ? TAIL : ENC;
        end
      end
      ENC: begin
        if (accept) begin
          step = 1'b1;
          if (in_last) begin
            tail_nx  = '0;
            state_nx = TAIL;
          end
        end
      end
      TAIL: begin
        if (adv) begin
          step    = 1'b1;
          tail_nx = tail_cnt + TAIL_CNT_W'(1);
          if (tail_cnt == TAIL_CNT_W'(TAIL_LEN - 1)) begin
            out_last_nx = 1'b1;
            state_nx    = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (step) begin
      sr_nx        = {step_bit, sr[STATE_W-1:1]};
      out_valid_nx = 1'b1;
      out_data_nx  = sym_c;
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= 2'b00;
      out_mask  <= 2'b11;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      tail_cnt  <= tail_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_mask  <= out_mask_nx;
      out_last  <= out_last_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_conv_enc_k7.sv
// Self-checking bench for conv_enc_k7: polynomial reference model, scoreboard queue,
// directed impulse/zero/backpressure/back-to-back/reset cases and random frames.
module tb_conv_enc_k7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_data = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic [1:0] out_mask;
  logic       out_last;
  logic       busy;

  conv_enc_k7 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] data;
    logic [1:0] mask;
    logic       last;
  } sym_t;

  int   n_checks = 0;
  int   n_fail = 0;
  sym_t exp_q[$];
  int   ready_mode = 0;
  int   ready_phase = 0;
  logic checking = 1'b0;
  logic no_bubble = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: convolve input+tail with the generator polynomials, bit by bit.
  function automatic void model_frame(input bit bits[$], output sym_t syms[$]);
    bit [6:0] g0 = 7'o171;
    bit [6:0] g1 = 7'o133;
    bit       x[$];
    bit       c0, c1, tap;
    sym_t     s;
    x = bits;
    for (int i = 0; i < 6; i++) x.push_back(1'b0);
    syms.delete();
    for (int n = 0; n < x.size(); n++) begin
      c0 = 1'b0;
      c1 = 1'b0;
      for (int k = 0; k < 7; k++) begin
        tap = (n - k >= 0) ? x[n-k] : 1'b0;
        if (g0[6-k]) c0 ^= tap;
        if (g1[6-k]) c1 ^= tap;
      end
      s.data = {c1, c0};
`ifdef CONV_PUNCT_EN
      s.mask = (n % 2 == 1) ? 2'b01 : 2'b11;
`else
      s.mask = 2'b11;
`endif
      s.last = (n == x.size() - 1);
      syms.push_back(s);
    end
  endfunction

  // out_ready pattern generator: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (ready_phase % 3 == 0);
        ready_phase++;
      end
    endcase
  end

  // Scoreboard compare and hold/stall checks, sampled on the falling edge.
  logic stalled = 1'b0;
  sym_t held;
  logic last_popped = 1'b0;
  sym_t e;
  always @(negedge clk) begin
    if (!rst_n || !checking) begin
      stalled = 1'b0;
      last_popped = 1'b0;
    end else begin
      if (last_popped && no_bubble && exp_q.size() != 0)
        check("no_bubble_valid", 32'(out_valid), 32'd1);
      last_popped = 1'b0;
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sym", 32'({out_data, out_mask, out_last}), 32'(held));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (!out_last) check("busy_mid_frame", 32'(busy), 32'd1);
        if (!out_ready) begin
          check("in_ready_stall", 32'(in_ready), 32'd0);
          stalled = 1'b1;
          held = {out_data, out_mask, out_last};
        end else if (exp_q.size() == 0) begin
          check("unexpected_sym", 32'({out_data, out_mask, out_last}), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("sym_data", 32'(out_data), 32'(e.data));
          check("sym_mask", 32'(out_mask), 32'(e.mask));
          check("sym_last", 32'(out_last), 32'(e.last));
          last_popped = out_last;
        end
      end
    end
  end

  task automatic send_frame(input bit bits[$], input int gap_pct);
    sym_t syms[$];
    int   t;
    model_frame(bits, syms);
    foreach (syms[i]) exp_q.push_back(syms[i]);
    for (int i = 0; i < bits.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = bits[i];
      in_last  = (i == bits.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        @(posedge clk);
        #1;
        t++;
        if (t > 1000) begin
          check("accept_timeout", 32'd1, 32'd0);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", 32'(t >= 3000), 32'd0);
    @(posedge clk);
    #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  bit   frame[$];
  sym_t ref_syms[$];
  logic [1:0] imp_data[7];
  logic [1:0] imp_mask[7];

  initial begin
    imp_data = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
`ifdef CONV_PUNCT_EN
    imp_mask = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
`else
    imp_mask = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd3);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the model with hand-derived impulse and zero-frame results
    frame = '{1'b1};
    model_frame(frame, ref_syms);
    check("model_imp_len", 32'(ref_syms.size()), 32'd7);
    foreach (ref_syms[i]) begin
      check("model_imp_data", 32'(ref_syms[i].data), 32'(imp_data[i]));
      check("model_imp_mask", 32'(ref_syms[i].mask), 32'(imp_mask[i]));
      check("model_imp_last", 32'(ref_syms[i].last), 32'(i == 6));
    end
    frame = '{0, 0, 0, 0, 0, 0, 0, 0};
    model_frame(frame, ref_syms);
    check("model_zero_len", 32'(ref_syms.size()), 32'd14);
    foreach (ref_syms[i]) check("model_zero_data", 32'(ref_syms[i].data), 32'd0);

    checking = 1'b1;

    // Impulse
    ready_mode = 0;
    frame = '{1'b1};
    send_frame(frame, 0);
    drain();

    // All-zero 8-bit frame
    frame = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(frame, 0);
    drain();

    // Impulse under backpressure
    ready_mode = 2;
    ready_phase = 0;
    frame = '{1'b1};
    send_frame(frame, 0);
    drain();

    // Back-to-back frames, in_valid held high
    ready_mode = 0;
    no_bubble = 1'b1;
    frame = '{1, 0, 1};
    send_frame(frame, 0);
    frame = '{1'b1};
    send_frame(frame, 0);
    drain();
    no_bubble = 1'b0;

    // Reset during the tail of an impulse frame
    frame = '{1'b1};
    send_frame(frame, 0);
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() <= 4) break;
    end
    rst_n = 1'b0;
    checking = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;
    send_frame(frame, 0);
    drain();

    // Random frames with random gaps and backpressure
    ready_mode = 1;
    for (int f = 0; f < 25; f++) begin
      frame.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) frame.push_back(1'($urandom_range(0, 1)));
      send_frame(frame, 30);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
